mdio_responder: RTL and testbench
=================================

Name: mdio_responder

Overview:
- Management-side MDIO target (Clause 22 responder), the far end of the team's MDIO master controller.
- Oversamples MDC/MDIO in the 125 MHz domain and decodes read and write frames addressed to PHY_ADDR.
- Exposes a simple register-port handshake so an emulated PHY register file or a loopback bench can serve the frames.
- Drives MDIO through the bidirectional pad cell: mdio_t=1 releases the line, mdio_t=0 drives it.

Parameters:
- PHY_ADDR, 5'd0, PHY address this responder answers to.
- MIN_PREAMBLE, 32, consecutive sampled 1s required before a start sequence is accepted.
- SYNC_STAGES, 2, synchronizer depth on mdc_i and mdio_i.
- TIMEOUT, 4096, clk cycles without an MDC rising edge before an in-progress frame is aborted.

Ports:
- clk  in  1  125 MHz system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- mdc_i  in  1  MDC from master, asynchronous to clk.
- mdio_i  in  1  MDIO from pad.
- mdio_o  out  1  MDIO value to pad.
- mdio_t  out  1  pad tristate, 1 = released.
- reg_addr  out  5  register address, held from REGAD capture until the frame ends.
- reg_rd  out  1  one-clk read strobe.
- reg_rdata  in  16  read data, valid 1 clk after reg_rd.
- reg_wr  out  1  one-clk write strobe.
- reg_wdata  out  16  write data, valid while reg_wr=1 and held afterwards.
- busy  out  1  high from the clock after the start is accepted until return to IDLE.
- frame_err  out  1  one-clk pulse on an aborted frame.

Behaviour:
- Reset values: mdio_o=1, mdio_t=1, reg_addr=0, reg_rd=0, reg_wr=0, reg_wdata=0, busy=0, frame_err=0, state=IDLE, counters=0.
- Reset is applied asynchronously, including mid-frame; a read in progress releases the bus immediately.
- mdc_i and mdio_i pass through SYNC_STAGES flops each.
- A rise is detected when the current synced MDC is 1 and the previous synced MDC is 0. All protocol sampling uses synced MDIO on a detected rise.
- MDC high and low phases must each be at least SYNC_STAGES+2 clk cycles.
- States: IDLE, START, OP, PHYAD, REGAD, TA, WDATA, RDATA.
- IDLE: a sampled 1 increments the preamble count, saturating at MIN_PREAMBLE. A sampled 0 with count==MIN_PREAMBLE goes to START. Any other 0 clears the count.
- START: sample 1 -> OP. Sample 0 -> IDLE with frame_err.
- OP: 2 bits, MSB first. 10 = read, 01 = write. 00 or 11 -> IDLE with frame_err (Clause 45 unsupported).
- PHYAD: 5 bits, MSB first. On mismatch with PHY_ADDR -> IDLE silently, no err.
- REGAD: 5 bits. The rise sampling the last bit is E0; reg_addr updates at E0.
  - Read: reg_rd pulses at E0. reg_rdata is captured into the shift register on the following clk.
  - Then -> TA.
- TA, read:
  - E0+1: mdio_t=0, mdio_o=0.
  - E0+2: drive D15, then one bit per rise through D0 at E0+17.
  - E0+18: mdio_t=1, mdio_o=1, -> IDLE.
- TA, write: the two TA bits are ignored, not checked.
  - Data bits are sampled at E0+3..E0+18, MSB first.
  - At E0+18: reg_wdata is loaded and reg_wr pulses for 1 clk, -> IDLE.
- Outputs change only on the clk following a detected rise. The responder never drives during a write or a non-matching frame.
- Timeout: the counter resets on every rise and counts otherwise. Reaching TIMEOUT-1 in any non-IDLE state -> IDLE, bus released, frame_err pulse.
- On every return to IDLE the preamble count clears, so a new frame needs a full preamble.
- 1s in data do not pre-load the count.
- Back-to-back frames with exactly MIN_PREAMBLE ones between them are accepted.
- busy drops on the clk of the return to IDLE.

Test Plan:
- Write, PHY_ADDR=1: preamble 32x1, 01, 01, 00001, 00100, TA 10, data 0xA5C3 -> one reg_wr with reg_addr=4, reg_wdata=0xA5C3; mdio_t stays 1 throughout.
- Read, reg_rdata=0x1234, REGAD=2: sampled line shows TA2=0 then 0001001000110100. reg_rd pulses once at E0, mdio_t=0 for exactly 17 MDC periods.
- PHYAD=3 when PHY_ADDR=1: no strobes, no frame_err, mdio_t=1 throughout; an immediately following correct frame decodes.
- Preamble of 31 ones, then 0110...: frame ignored, no strobe. With 32 ones the same frame is accepted. Opcode 11 after a valid preamble -> frame_err pulse, no strobe.
- rst_n low at D8 of a read: mdio_t=1 asynchronously, all outputs at reset values. After release, the next full frame works.
- MDC stops after REGAD of a read: after TIMEOUT clks, mdio_t=1, frame_err pulse, busy=0.

Source files
------------

// File: rtl/mdio_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mdio_responder
// Purpose  : Clause 22 MDIO target; oversamples MDC/MDIO and serves read and
//            write frames through a one-clk register-port handshake.
// Revision : 1.0 - initial release
// ============================================================================
module mdio_responder #(
    parameter logic [4:0] PHY_ADDR     = 5'd0,
    parameter int         MIN_PREAMBLE = 32,
    parameter int         SYNC_STAGES  = 2,
    parameter int         TIMEOUT      = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mdc_i,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_t,
    output logic [4:0]  reg_addr,
    output logic        reg_rd,
    input  logic [15:0] reg_rdata,
    output logic        reg_wr,
    output logic [15:0] reg_wdata,
    output logic        busy,
    output logic        frame_err
);

    localparam int             c_PRE_W   = $clog2(MIN_PREAMBLE + 1);
    localparam int             c_TMO_W   = $clog2(TIMEOUT);
    localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(MIN_PREAMBLE);
    localparam logic [c_TMO_W-1:0] c_TMO_MAX = c_TMO_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_START = 4'd1,
        S_OP    = 4'd2,
        S_PHYAD = 4'd3,
        S_REGAD = 4'd4,
        S_TA    = 4'd5,
        S_WDATA = 4'd6,
        S_RDATA = 4'd7
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_mdc_sync;
    logic [SYNC_STAGES-1:0] r_mdio_sync;
    logic                   r_mdc_prev;
    logic [c_PRE_W-1:0]     r_pre;
    logic [c_TMO_W-1:0]     r_tmo;
    logic [3:0]             r_cnt;
    logic                   r_op_msb;
    logic                   r_is_read;
    logic [15:0]            r_shift;

    logic       w_mdc_s;
    logic       w_mdio_s;
    logic       w_rise;
    logic [4:0] w_addr5;

    assign w_mdc_s  = r_mdc_sync[SYNC_STAGES-1];
    assign w_mdio_s = r_mdio_sync[SYNC_STAGES-1];
    assign w_rise   = w_mdc_s & ~r_mdc_prev;
    assign w_addr5  = {r_shift[3:0], w_mdio_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mdc_sync  <= '0;
            r_mdio_sync <= '0;
            r_mdc_prev  <= 1'b0;
            r_pre       <= '0;
            r_tmo       <= '0;
            r_cnt       <= 4'd0;
            r_op_msb    <= 1'b0;
            r_is_read   <= 1'b0;
            r_shift     <= 16'd0;
            mdio_o      <= 1'b1;
            mdio_t      <= 1'b1;
            reg_addr    <= 5'd0;
            reg_rd      <= 1'b0;
            reg_wr      <= 1'b0;
            reg_wdata   <= 16'd0;
            busy        <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            r_mdc_sync[0]  <= mdc_i;
            r_mdio_sync[0] <= mdio_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_mdc_sync[i]  <= r_mdc_sync[i-1];
                r_mdio_sync[i] <= r_mdio_sync[i-1];
            end
            r_mdc_prev <= w_mdc_s;
            reg_rd     <= 1'b0;
            reg_wr     <= 1'b0;
            frame_err  <= 1'b0;

            // Register port answers one clk after the read strobe
            if (reg_rd)
                r_shift <= reg_rdata;

            if (r_state == S_IDLE || w_rise)
                r_tmo <= '0;
            else
                r_tmo <= r_tmo + 1'b1;

            if (r_state != S_IDLE && !w_rise && r_tmo == c_TMO_MAX) begin
                r_state   <= S_IDLE;
                r_pre     <= '0;
                busy      <= 1'b0;
                mdio_t    <= 1'b1;
                mdio_o    <= 1'b1;
                frame_err <= 1'b1;
            end else if (w_rise) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_mdio_s) begin
                            if (r_pre != c_PRE_MAX)
                                r_pre <= r_pre + 1'b1;
                        end else if (r_pre == c_PRE_MAX) begin
                            r_state <= S_START;
                            r_pre   <= '0;
                            busy    <= 1'b1;
                        end else begin
                            r_pre <= '0;
                        end
                    end
                    S_START: begin
                        if (w_mdio_s) begin
                            r_state <= S_OP;
                            r_cnt   <= 4'd0;
                        end else begin
                            r_state   <= S_IDLE;
                            busy      <= 1'b0;
                            frame_err <= 1'b1;
                        end
                    end
                    S_OP: begin
                        if (r_cnt == 4'd0) begin
                            r_op_msb <= w_mdio_s;
                            r_cnt    <= 4'd1;
                        end else if (r_op_msb != w_mdio_s) begin
                            r_is_read <= r_op_msb;
                            r_state   <= S_PHYAD;
                            r_cnt     <= 4'd0;
                        end else begin
                            r_state   <= S_IDLE;
                            busy      <= 1'b0;
                            frame_err <= 1'b1;
                        end
                    end
                    S_PHYAD: begin
                        r_shift <= {r_shift[14:0], w_mdio_s};
                        if (r_cnt == 4'd4) begin
                            r_cnt <= 4'd0;
                            if (w_addr5 == PHY_ADDR) begin
                                r_state <= S_REGAD;
                            end else begin
                                r_state <= S_IDLE;
                                busy    <= 1'b0;
                            end
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                    S_REGAD: begin
                        r_shift <= {r_shift[14:0], w_mdio_s};
                        if (r_cnt == 4'd4) begin
                            reg_addr <= w_addr5;
                            reg_rd   <= r_is_read;
                            r_state  <= S_TA;
                            r_cnt    <= 4'd0;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                    S_TA: begin
                        if (r_cnt == 4'd0) begin
                            r_cnt <= 4'd1;
                            if (r_is_read) begin
                                mdio_t <= 1'b0;
                                mdio_o <= 1'b0;
                            end
                        end else if (r_is_read) begin
                            mdio_o  <= r_shift[15];
                            r_shift <= {r_shift[14:0], 1'b0};
                            r_cnt   <= 4'd15;
                            r_state <= S_RDATA;
                        end else begin
                            r_cnt   <= 4'd0;
                            r_state <= S_WDATA;
                        end
                    end
                    S_WDATA: begin
                        r_shift <= {r_shift[14:0], w_mdio_s};
                        if (r_cnt == 4'd15) begin
                            reg_wdata <= {r_shift[14:0], w_mdio_s};
                            reg_wr    <= 1'b1;
                            r_state   <= S_IDLE;
                            busy      <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                    S_RDATA: begin
                        if (r_cnt == 4'd0) begin
                            mdio_t  <= 1'b1;
                            mdio_o  <= 1'b1;
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            mdio_o  <= r_shift[15];
                            r_shift <= {r_shift[14:0], 1'b0};
                            r_cnt   <= r_cnt - 4'd1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdio_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mdio_responder
// Purpose  : Directed MDIO master stimulus with a register-port scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdio_responder;

    localparam int TMO = 512;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mdc = 1'b0;
    logic        mdio_m = 1'b1;
    logic        line;
    logic        mdio_o;
    logic        mdio_t;
    logic [4:0]  reg_addr;
    logic        reg_rd;
    logic [15:0] reg_rdata = 16'd0;
    logic        reg_wr;
    logic [15:0] reg_wdata;
    logic        busy;
    logic        frame_err;

    int n_assert = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int rd_cnt   = 0;
    int err_cnt  = 0;
    int drive_bits = 0;
    logic [63:0] seen = '0;

    typedef struct packed {
        logic [4:0]  a;
        logic [15:0] d;
    } wr_t;
    wr_t        exp_wr[$];
    logic [4:0] exp_rd[$];
    wr_t        e_wr;
    logic [4:0] e_rd;

    assign line = mdio_t ? mdio_m : mdio_o;

    mdio_responder #(
        .PHY_ADDR    (5'd1),
        .MIN_PREAMBLE(32),
        .SYNC_STAGES (2),
        .TIMEOUT     (TMO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mdc_i    (mdc),
        .mdio_i   (line),
        .mdio_o   (mdio_o),
        .mdio_t   (mdio_t),
        .reg_addr (reg_addr),
        .reg_rd   (reg_rd),
        .reg_rdata(reg_rdata),
        .reg_wr   (reg_wr),
        .reg_wdata(reg_wdata),
        .busy     (busy),
        .frame_err(frame_err)
    );

    always #4 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: strobes pop the expectation pushed when the frame was sent
    always @(negedge clk) begin
        if (rst_n) begin
            if (reg_wr) begin
                wr_cnt++;
                check("wr_pending", 32'(exp_wr.size() > 0), 32'd1);
                if (exp_wr.size() > 0) begin
                    e_wr = exp_wr.pop_front();
                    check("wr_addr", 32'(reg_addr), 32'(e_wr.a));
                    check("wr_data", 32'(reg_wdata), 32'(e_wr.d));
                end
            end
            if (reg_rd) begin
                rd_cnt++;
                check("rd_pending", 32'(exp_rd.size() > 0), 32'd1);
                if (exp_rd.size() > 0) begin
                    e_rd = exp_rd.pop_front();
                    check("rd_addr", 32'(reg_addr), 32'(e_rd));
                end
            end
            if (frame_err)
                err_cnt++;
        end
    end

    task automatic mdc_bit(input logic b);
        mdio_m = b;
        mdc    = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        seen = {seen[62:0], line};
        if (!mdio_t)
            drive_bits++;
        mdc = 1'b1;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--)
            mdc_bit(v[i]);
    endtask

    task automatic preamble(input int n);
        for (int i = 0; i < n; i++)
            mdc_bit(1'b1);
    endtask

    task automatic header(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra);
        send(32'h1, 2);
        send(32'(op), 2);
        send(32'(phy), 5);
        send(32'(ra), 5);
    endtask

    task automatic write_frame(input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] d);
        preamble(32);
        header(2'b01, phy, ra);
        send(32'h2, 2);
        send(32'(d), 16);
    endtask

    task automatic read_frame(input logic [4:0] phy, input logic [4:0] ra);
        preamble(32);
        header(2'b10, phy, ra);
        send(32'h3FFFF, 18);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, r0, e0, waited;

        // Reset state
        repeat (5) @(posedge clk);
        #1;
        check("rst_mdio_t", 32'(mdio_t), 32'd1);
        check("rst_mdio_o", 32'(mdio_o), 32'd1);
        check("rst_rd_wr", 32'({reg_rd, reg_wr}), 32'd0);
        check("rst_busy_err", 32'({busy, frame_err}), 32'd0);
        check("rst_addr", 32'(reg_addr), 32'd0);
        check("rst_wdata", 32'(reg_wdata), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // Write 0xA5C3 to register 4
        drive_bits = 0;
        exp_wr.push_back({5'd4, 16'hA5C3});
        preamble(32);
        header(2'b01, 5'd1, 5'd4);
        check("wr_busy_mid", 32'(busy), 32'd1);
        send(32'h2, 2);
        send(32'hA5C3, 16);
        check("wr_count", 32'(wr_cnt), 32'd1);
        check("wr_no_drive", 32'(drive_bits), 32'd0);
        check("wr_busy_end", 32'(busy), 32'd0);

        // Read 0x1234 from register 2
        reg_rdata  = 16'h1234;
        drive_bits = 0;
        exp_rd.push_back(5'd2);
        read_frame(5'd1, 5'd2);
        check("rd_count", 32'(rd_cnt), 32'd1);
        check("rd_ta1_released", 32'(seen[17]), 32'd1);
        check("rd_line", 32'(seen[16:0]), {15'd0, 1'b0, 16'h1234});
        check("rd_drive_periods", 32'(drive_bits), 32'd17);
        check("rd_released", 32'(mdio_t), 32'd1);
        check("rd_busy_end", 32'(busy), 32'd0);

        // Non-matching PHY address, then an immediate correct frame
        w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
        drive_bits = 0;
        read_frame(5'd3, 5'd2);
        check("mis_no_drive", 32'(drive_bits), 32'd0);
        check("mis_no_strobe", 32'((wr_cnt - w0) + (rd_cnt - r0)), 32'd0);
        check("mis_no_err", 32'(err_cnt - e0), 32'd0);
        exp_wr.push_back({5'd7, 16'h0F0F});
        write_frame(5'd1, 5'd7, 16'h0F0F);
        check("mis_next_wr", 32'(wr_cnt - w0), 32'd1);

        // 31-one preamble is ignored; 32 ones accepted
        w0 = wr_cnt;
        preamble(31);
        header(2'b01, 5'd1, 5'd5);
        send(32'h2, 2);
        send(32'h5A5A, 16);
        check("pre31_ignored", 32'(wr_cnt - w0), 32'd0);
        exp_wr.push_back({5'd5, 16'h5A5A});
        write_frame(5'd1, 5'd5, 16'h5A5A);
        check("pre32_accepted", 32'(wr_cnt - w0), 32'd1);

        // Opcode 11 aborts with a single error pulse
        w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
        preamble(32);
        send(32'h1, 2);
        send(32'h3, 2);
        check("op11_err", 32'(err_cnt - e0), 32'd1);
        check("op11_busy", 32'(busy), 32'd0);
        send(32'h1, 5);
        send(32'h4, 5);
        send(32'h3FFFF, 18);
        check("op11_no_strobe", 32'((wr_cnt - w0) + (rd_cnt - r0)), 32'd0);

        // Asynchronous reset while D8 of a read is on the line
        reg_rdata = 16'hBEEF;
        exp_rd.push_back(5'd9);
        preamble(32);
        header(2'b10, 5'd1, 5'd9);
        send(32'h1FF, 9);
        check("rst_mid_driving", 32'(mdio_t), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_t", 32'(mdio_t), 32'd1);
        check("rst_mid_o", 32'(mdio_o), 32'd1);
        check("rst_mid_state", 32'({busy, reg_addr, reg_rd, reg_wr}), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        reg_rdata = 16'hC0DE;
        exp_rd.push_back(5'd5);
        r0 = rd_cnt;
        read_frame(5'd1, 5'd5);
        check("rst_next_rd", 32'(rd_cnt - r0), 32'd1);
        check("rst_next_line", 32'(seen[16:0]), {15'd0, 1'b0, 16'hC0DE});

        // MDC stops just after the turnaround starts
        reg_rdata = 16'h0001;
        exp_rd.push_back(5'd3);
        preamble(32);
        header(2'b10, 5'd1, 5'd3);
        mdc_bit(1'b1);
        check("tmo_driving", 32'(mdio_t), 32'd0);
        e0 = err_cnt;
        waited = 0;
        while (err_cnt == e0 && waited < TMO + 100) begin
            @(posedge clk);
            waited++;
        end
        #1;
        check("tmo_err", 32'(err_cnt - e0), 32'd1);
        check("tmo_window", 32'((waited >= TMO - 16) && (waited <= TMO)), 32'd1);
        check("tmo_released", 32'(mdio_t), 32'd1);
        check("tmo_busy", 32'(busy), 32'd0);
        exp_wr.push_back({5'd1, 16'h8001});
        w0 = wr_cnt;
        write_frame(5'd1, 5'd1, 16'h8001);
        check("tmo_recover", 32'(wr_cnt - w0), 32'd1);
        check("queues_drained", 32'(exp_wr.size() + exp_rd.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
